// File: rtl/mux_lfmr_handshake_pkg.sv
// Shared FSM encodings and the settle-counter width helper for mux_lfmr_handshake.
package mux_lfmr_handshake_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   // Counter must hold 0..LATENCY; a zero-latency mux still needs one bit.
   function automatic int cnt_w(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/mux_lfmr.sv
// Latency-parameterised mux: select stage followed by LATENCY unreset register stages.
// TYPE picks the select structure (0 fixed index, 1 and-or, 2 prioritized compare chain).
module mux_lfmr #(
   parameter int WIDTH       = 1,
   parameter int INPUT_COUNT = 2,
   parameter int LATENCY     = 0,
   parameter int TYPE        = 0
) (
   input  logic                             clk,
   input  logic [$clog2(INPUT_COUNT):0]     sel,
   input  logic [WIDTH*INPUT_COUNT-1:0]     in,
   output logic [WIDTH-1:0]                 out
);

   localparam int SW = $clog2(INPUT_COUNT) + 1;
   localparam logic [SW-1:0] SEL_LIM = SW'(INPUT_COUNT);

   logic [WIDTH-1:0] sel_word;

   // Out-of-range selects yield zero in every structure.
   always_comb begin
      sel_word = '0;
      if (TYPE == 2) begin
         for (int k = INPUT_COUNT - 1; k >= 0; k--)
            if (sel == SW'(k)) sel_word = in[WIDTH*k +: WIDTH];
      end else if (TYPE == 1) begin
         for (int k = 0; k < INPUT_COUNT; k++)
            sel_word = sel_word | (in[WIDTH*k +: WIDTH] & {WIDTH{sel == SW'(k)}});
      end else begin
         if (sel < SEL_LIM) sel_word = in[WIDTH*int'(sel) +: WIDTH];
      end
   end

   generate
      if (LATENCY > 0) begin : g_pipe
         logic [LATENCY-1:0][WIDTH-1:0] stg;
         always_ff @(posedge clk) begin
            stg[0] <= sel_word;
            for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
         end
         assign out = stg[LATENCY-1];
      end else begin : g_comb
         assign out = sel_word;
      end
   endgenerate

endmodule

// File: rtl/mux_lfmr_handshake.sv
// Valid/ready wrapper around mux_lfmr: captures a request, holds it LATENCY+1 clocks, registers result.
// Optional: MUX_LFMR_HS_RANGE_CHECK_EN flags sel>=INPUT_COUNT via out_err with out forced to 0.
module mux_lfmr_handshake
   import mux_lfmr_handshake_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int INPUT_COUNT = 2,
   parameter int LATENCY     = 0,
   parameter int TYPE        = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [$clog2(INPUT_COUNT):0]     sel,
   input  logic [WIDTH*INPUT_COUNT-1:0]     in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WIDTH-1:0]                 out,
   output logic                             out_err
);

   localparam int SW = $clog2(INPUT_COUNT) + 1;
   localparam int CW = cnt_w(LATENCY);
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);

   logic [1:0]                   state;
   logic [CW-1:0]                cnt;
   logic [SW-1:0]                sel_q;
   logic [WIDTH*INPUT_COUNT-1:0] in_q;
   logic [WIDTH-1:0]             mux_out;
   logic [WIDTH-1:0]             res_word;

   // Inner mux sees only the captured request, so port changes during SETTLE are harmless.
   mux_lfmr #(
      .WIDTH(WIDTH), .INPUT_COUNT(INPUT_COUNT), .LATENCY(LATENCY), .TYPE(TYPE)
   ) u_mux (
      .clk(clk), .sel(sel_q), .in(in_q), .out(mux_out)
   );

   wire accept  = (state == IDLE) && in_valid;
   wire finish  = (state == SETTLE) && (cnt == CNT_LAST);

`ifdef MUX_LFMR_HS_RANGE_CHECK_EN
   localparam logic [SW-1:0] SEL_LIM = SW'(INPUT_COUNT);
   logic err_q, err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         err_r <= 1'b0;
      end else begin
         if (accept) err_q <= (sel >= SEL_LIM);
         if (finish) err_r <= err_q;
      end
   end

   assign res_word = err_q ? '0 : mux_out;
   assign out_err  = err_r;
`else
   assign res_word = mux_out;
   assign out_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_q     <= '0;
         in_q      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sel_q <= sel;
               in_q  <= in;
               cnt   <= '0;
               state <= SETTLE;
            end
            SETTLE: if (cnt == CNT_LAST) begin
               out       <= res_word;
               out_valid <= 1'b1;
               state     <= DONE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);

endmodule
